mio_bus_ctrl: RTL and testbench

- Memory/IO bus controller directly downstream of the multi-cycle CPU.
- Consumes the CPU request (CPU_MIO, mem_w, Addr_out, Data_out) and returns Data_in and MIO_ready.
- Decodes each access to a synchronous block RAM or to a small peripheral set (switch/LED GPIO, free-running timer with compare), and inserts wait states.
- Drives the CPU INT line from a timer-compare interrupt.

---
 rtl/mio_pkg.sv | 26 ++
 rtl/mio_timer.sv | 34 +++
 rtl/mio_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU memory/IO bus controller and its timer.
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM,
        IO,
        DONE
    } mio_state_t;

    localparam logic [1:0] IO_IDX_GPIO  = 2'd0;
    localparam logic [1:0] IO_IDX_TIMER = 2'd1;
    localparam logic [1:0] IO_IDX_IRQ   = 2'd2;
    localparam logic [1:0] IO_IDX_NONE  = 2'd3;

    localparam logic [3:0] IO_NIB_DEF = 4'hF;

    // Request fields latched on acceptance; the word address is kept separately
    // because its width follows the RAM size parameter.
    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] dat;
    } req_t;

endpackage

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with compare and sticky interrupt; count updates every cycle.
// Compare/clear strobes take effect at the next edge; a compare hit in the same cycle as a clear wins.
module mio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmp_we,
    input  logic [31:0] cmp_dat,
    input  logic        irq_clr,
    output logic [31:0] count,
    output logic        irq_pending
);

    logic [31:0] compare;

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            compare     <= '0;
            irq_pending <= 1'b0;
        end else begin
            count <= count + 32'd1;
            if (cmp_we) begin
                compare <= cmp_dat;
            end
            // A compare of zero disables the interrupt entirely.
            if ((count == compare) && (compare != '0)) begin
                irq_pending <= 1'b1;
            end else if (irq_clr) begin
                irq_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: decodes to block RAM or GPIO/timer registers, ready at T+2 (IO, RAM write) or T+2+RAM_LAT (RAM read).
// CPU holds the request until MIO_ready; optional MIO_BUS_ERR_EN adds bus_err for unmapped accesses.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int         RAM_AW  = 10,
    parameter int         RAM_LAT = 1,
    parameter logic [3:0] IO_NIB  = IO_NIB_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              INT,
`ifdef MIO_BUS_ERR_EN
    output logic              bus_err,
`endif
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out
);

    mio_state_t        state;
    req_t              req;
    logic [RAM_AW-1:0] waddr;
    logic [1:0]        wait_cnt;
    logic              is_io;
    logic              req_err;
    logic              io_wr;
    logic [31:0]       io_rdata;
    logic [31:0]       tmr_count;
    logic              irq_pending;
    logic              unused_addr_bits;

    assign is_io = (Addr_out[31:28] == IO_NIB);

`ifdef MIO_BUS_ERR_EN
    assign req_err = is_io ? (Addr_out[3:2] == IO_IDX_NONE)
                           : (Addr_out[31:RAM_AW+2] != '0);
`else
    assign req_err = 1'b0;
`endif

    assign unused_addr_bits = ^{Addr_out[27:RAM_AW+2], Addr_out[1:0]};

    assign ram_addr = waddr;
    assign ram_din  = req.dat;
    assign INT      = irq_pending;
    assign io_wr    = (state == IO) && req.we && !req.err;

    mio_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .cmp_we      (io_wr && (waddr[1:0] == IO_IDX_TIMER)),
        .cmp_dat     (req.dat),
        .irq_clr     (io_wr && (waddr[1:0] == IO_IDX_IRQ)),
        .count       (tmr_count),
        .irq_pending (irq_pending)
    );

    always_comb begin
        io_rdata = '0;
        case (waddr[1:0])
            IO_IDX_GPIO:  io_rdata = {16'b0, sw_in};
            IO_IDX_TIMER: io_rdata = tmr_count;
            IO_IDX_IRQ:   io_rdata = {31'b0, irq_pending};
            default:      io_rdata = '0;
        endcase
        if (req.err) begin
            io_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req       <= '0;
            waddr     <= '0;
            wait_cnt  <= '0;
            Data_in   <= '0;
            MIO_ready <= 1'b0;
            ram_we    <= 1'b0;
            led_out   <= '0;
`ifdef MIO_BUS_ERR_EN
            bus_err   <= 1'b0;
`endif
        end else begin
            MIO_ready <= 1'b0;
            ram_we    <= 1'b0;
`ifdef MIO_BUS_ERR_EN
            bus_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (CPU_MIO) begin
                        req      <= '{we: mem_w, err: req_err, dat: Data_out};
                        waddr    <= Addr_out[RAM_AW+1:2];
                        wait_cnt <= '0;
                        // Faulting RAM accesses take the one-cycle IO path so they never touch the RAM.
                        if (is_io || req_err) begin
                            state <= IO;
                        end else begin
                            state  <= RAM;
                            ram_we <= mem_w;
                        end
                    end
                end
                RAM: begin
                    if (req.we) begin
                        state     <= DONE;
                        MIO_ready <= 1'b1;
                    end else if (wait_cnt == 2'(RAM_LAT)) begin
                        Data_in   <= ram_dout;
                        state     <= DONE;
                        MIO_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                IO: begin
                    if (!req.we) begin
                        Data_in <= io_rdata;
                    end
                    if (io_wr && (waddr[1:0] == IO_IDX_GPIO)) begin
                        led_out <= req.dat[15:0];
                    end
`ifdef MIO_BUS_ERR_EN
                    bus_err   <= req.err;
`endif
                    state     <= DONE;
                    MIO_ready <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: stimulus pushes expected completions, a monitor checks each MIO_ready.
module tb_mio_bus_ctrl;

    localparam int RAM_AW  = 10;
    localparam int RAM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              CPU_MIO = 1'b0;
    logic              mem_w = 1'b0;
    logic [31:0]       Addr_out = '0;
    logic [31:0]       Data_out = '0;
    logic [31:0]       Data_in;
    logic              MIO_ready;
    logic              INT;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;
    logic [15:0]       sw_in = 16'h3C5A;
    logic [15:0]       led_out;
`ifdef MIO_BUS_ERR_EN
    logic              bus_err;
    localparam logic   ERR_EXP = 1'b1;
`else
    localparam logic   ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    mio_bus_ctrl #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .IO_NIB(4'hF)) dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .INT       (INT),
`ifdef MIO_BUS_ERR_EN
        .bus_err   (bus_err),
`endif
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    // Synchronous RAM model with RAM_LAT cycles of read latency and a preload port.
    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic [31:0]       pipe [0:RAM_LAT-1];
    logic              pl_en = 1'b0;
    logic [RAM_AW-1:0] pl_addr = '0;
    logic [31:0]       pl_dat = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (ram_we) mem[ram_addr] <= ram_din;
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout = pipe[RAM_LAT-1];

    typedef struct {
        string       name;
        logic [31:0] dat;
        int          cyc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   we_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (ram_we) we_cnt++;
        if (MIO_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_ready: got MIO_ready=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_data"}, Data_in, e.dat);
                check({e.name, "_cycle"}, cyc, e.cyc);
`ifdef MIO_BUS_ERR_EN
                check({e.name, "_bus_err"}, {31'b0, bus_err}, {31'b0, e.err});
`endif
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic err, input int lat);
        CPU_MIO  = 1'b1;
        mem_w    = we;
        Addr_out = a;
        Data_out = d;
        sb.push_back('{name, exp_d, cyc + lat, err});
    endtask

    task automatic wait_ready();
        int i = 0;
        while (!MIO_ready && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!MIO_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got no MIO_ready within 40 cycles, expected one");
            sb.delete();
        end
    endtask

    task automatic finish_req();
        wait_ready();
        @(posedge clk);
        #1;
        CPU_MIO = 1'b0;
    endtask

    task automatic txn(input string name, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic err, input int lat);
        issue(name, we, a, d, exp_d, err, lat);
        finish_req();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_Data_in"}, Data_in, 32'h0);
        check({tag, "_MIO_ready"}, {31'b0, MIO_ready}, 32'h0);
        check({tag, "_INT"}, {31'b0, INT}, 32'h0);
        check({tag, "_ram_we"}, {31'b0, ram_we}, 32'h0);
        check({tag, "_led_out"}, {16'b0, led_out}, 32'h0);
`ifdef MIO_BUS_ERR_EN
        check({tag, "_bus_err"}, {31'b0, bus_err}, 32'h0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        int          t;
        int          w0;

        // Preload RAM while reset is held.
        pl_en = 1'b1; pl_addr = 10'd3; pl_dat = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        pl_addr = 10'd0; pl_dat = 32'h0BAD_F00D;
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        r0 = cyc;
        reset = 1'b0;

        // Timer compare: count equals cycles since reset release.
        txn("cmp_wr", 1'b1, 32'hF000_0004, 32'd20, 32'h0, 1'b0, 2);
        while (cyc < r0 + 20) @(negedge clk);
        check("int_before_hit", {31'b0, INT}, 32'h0);
        @(negedge clk);
        check("int_rise", {31'b0, INT}, 32'h1);
        repeat (5) @(negedge clk);
        check("int_hold", {31'b0, INT}, 32'h1);
        @(posedge clk); #1;
        txn("irq_rd", 1'b0, 32'hF000_0008, 32'h0, 32'h1, 1'b0, 2);
        issue("irq_clr", 1'b1, 32'hF000_0008, 32'hFFFF_FFFF, 32'h1, 1'b0, 2);
        @(negedge clk);
        @(negedge clk);
        check("int_during_clr", {31'b0, INT}, 32'h1);
        @(negedge clk);
        check("int_cleared", {31'b0, INT}, 32'h0);
        finish_req();

        // Compare hit in the same cycle as a clear: set must win.
        t = cyc + 12;
        txn("cmp_wr2", 1'b1, 32'hF000_0004, t + 1 - r0, 32'h1, 1'b0, 2);
        while (cyc < t) begin @(posedge clk); #1; end
        txn("irq_clr_race", 1'b1, 32'hF000_0008, 32'h0, 32'h1, 1'b0, 2);
        check("set_wins", {31'b0, INT}, 32'h1);
        txn("irq_clr2", 1'b1, 32'hF000_0008, 32'h0, 32'h1, 1'b0, 2);
        check("int_cleared2", {31'b0, INT}, 32'h0);

        // Timer count read: count sampled in the IO cycle after acceptance.
        t = cyc;
        txn("count_rd", 1'b0, 32'hF000_0004, 32'h0, t + 1 - r0, 1'b0, 2);

        // GPIO: LED write leaves Data_in alone; switch read with don't-care upper IO bits.
        txn("led_wr", 1'b1, 32'hF000_0000, 32'h0000_A5A5, t + 1 - r0, 1'b0, 2);
        check("led_out", {16'b0, led_out}, 32'h0000_A5A5);
        txn("sw_rd", 1'b0, 32'hFABC_0000, 32'h0, 32'h0000_3C5A, 1'b0, 2);

        // RAM read with latency; request fields changing while busy must be ignored.
        issue("ram_rd3", 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0, 2 + RAM_LAT);
        @(posedge clk); #1;
        Addr_out = 32'h0000_0010; mem_w = 1'b1; CPU_MIO = 1'b0;
        @(negedge clk);
        check("ram_addr", {22'b0, ram_addr}, 32'd3);
        finish_req();

        // RAM write then readback.
        w0 = we_cnt;
        txn("ram_wr", 1'b1, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 2);
        check("ram_we_pulses", we_cnt - w0, 32'd1);
        check("ram_mem4", mem[4], 32'h1234_5678);
        txn("ram_rd4", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 2 + RAM_LAT);

        // Back-to-back: CPU_MIO still high after ready starts a new request.
        issue("b2b_a", 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0, 2 + RAM_LAT);
        wait_ready();
        @(posedge clk); #1;
        issue("b2b_b", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 2 + RAM_LAT);
        finish_req();

        // Unmapped IO index 3.
        txn("io3_rd", 1'b0, 32'hF000_000C, 32'h0, 32'h0, ERR_EXP, 2);
        txn("io3_wr", 1'b1, 32'hF000_000C, 32'h0000_FFFF, 32'h0, ERR_EXP, 2);
        check("led_after_io3", {16'b0, led_out}, 32'h0000_A5A5);

        // RAM address beyond the RAM size.
`ifdef MIO_BUS_ERR_EN
        w0 = we_cnt;
        txn("oor_wr", 1'b1, 32'h0000_1010, 32'hCAFE_F00D, 32'h0, 1'b1, 2);
        check("oor_no_we", we_cnt - w0, 32'd0);
        check("oor_mem4", mem[4], 32'h1234_5678);
        txn("oor_rd", 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 2);
`else
        txn("alias_rd", 1'b0, 32'h0000_1000, 32'h0, 32'h0BAD_F00D, 1'b0, 2 + RAM_LAT);
`endif

        // Reset during a RAM read wait state aborts it without a ready pulse.
        CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h0000_000C;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; CPU_MIO = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("abort");
        @(posedge clk); #1;
        r0 = cyc;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        txn("after_abort", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 2 + RAM_LAT);
        t = cyc;
        txn("count_after_rst", 1'b0, 32'hF000_0004, 32'h0, t + 1 - r0, 1'b0, 2);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
